// File: rtl/segasys1_pkg.sv
// ---------------------------------------------------------------------------
// segasys1_pkg
// Shared constants and types for the Sega System 1/2 sprite collision store.
//   COLL_AW       : collision RAM address width ({sprite[4:0], other[4:0]})
//   COLL_DEPTH    : collision RAM depth in bits
//   sweep_state_t : state of the full-RAM clear sweep
// ---------------------------------------------------------------------------
package segasys1_pkg;

    localparam int COLL_AW    = 10;
    localparam int COLL_DEPTH = 1 << COLL_AW;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/segasys1_sprcoll_if.sv
// ---------------------------------------------------------------------------
// segasys1_sprcoll_if
// Z80-side bus into the collision store.
//   CPU_AD     : bit address for read or clear
//   CPU_CS_RAM : selects the collision RAM
//   CPU_CS_SUM : selects the summary flag
//   CPU_WR     : single-cycle write pulse (any write clears)
//   CPU_DO     : read data {7'b1111111, bit}
// master = CPU side, slave = collision store.
// ---------------------------------------------------------------------------
interface segasys1_sprcoll_if
    import segasys1_pkg::*;
#(
    parameter int AW = COLL_AW
);

    logic [AW-1:0] CPU_AD;
    logic          CPU_CS_RAM;
    logic          CPU_CS_SUM;
    logic          CPU_WR;
    logic [7:0]    CPU_DO;

    modport master (
        output CPU_AD,
        output CPU_CS_RAM,
        output CPU_CS_SUM,
        output CPU_WR,
        input  CPU_DO
    );

    modport slave (
        input  CPU_AD,
        input  CPU_CS_RAM,
        input  CPU_CS_SUM,
        input  CPU_WR,
        output CPU_DO
    );

endinterface

// File: rtl/segasys1_sprcoll_ram.sv
// ---------------------------------------------------------------------------
// segasys1_sprcoll_ram
// 2^AW x 1 simple dual-port RAM: one synchronous write port, one synchronous
// read port. A read and write to the same address in one cycle return the
// old contents. No reset on storage or read register so it maps to block RAM.
//   clk     : clock
//   we      : write enable
//   wr_ad   : write address
//   wr_data : write data bit
//   rd_ad   : read address
//   rd_data : registered read data
// ---------------------------------------------------------------------------
module segasys1_sprcoll_ram
    import segasys1_pkg::*;
#(
    parameter int AW = COLL_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_ad,
    input  logic          wr_data,
    input  logic [AW-1:0] rd_ad,
    output logic          rd_data
);

    logic mem [0:(1 << AW) - 1];
    logic rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ad] <= wr_data;
        end
        rd_data_q <= mem[rd_ad];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/segasys1_sprcoll.sv
// ---------------------------------------------------------------------------
// segasys1_sprcoll
// Sprite-to-sprite collision store. Records each renderer collision strobe
// as a set bit in a 2^AW x 1 RAM and keeps a frame summary flag. The CPU
// reads bits / summary through the bus interface and clears them by writing.
// CLR_ALL starts a hardware sweep that zeroes the whole RAM.
//   VCLKx8     : clock
//   RST_N      : asynchronous active-low reset
//   SPRCOLL    : collision strobe from the sprite renderer
//   SPRCOLL_AD : collision address, valid while SPRCOLL=1
//   CLR_ALL    : pulse that starts (or restarts) the clear sweep
//   BUSY       : sweep in progress
//   SUMMARY    : a collision has been recorded since the last summary clear
//   cpu        : CPU bus (slave side)
// ---------------------------------------------------------------------------
module segasys1_sprcoll
    import segasys1_pkg::*;
#(
    parameter int AW = COLL_AW
) (
    input  logic               VCLKx8,
    input  logic               RST_N,
    input  logic               SPRCOLL,
    input  logic [AW-1:0]      SPRCOLL_AD,
    input  logic               CLR_ALL,
    output logic               BUSY,
    output logic               SUMMARY,
    segasys1_sprcoll_if.slave  cpu
);

    localparam logic [AW-1:0] LAST_AD = '1;

    sweep_state_t  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [AW-1:0] pend_ad_q, pend_ad_d;
    logic          summary_q, summary_d;
    logic          sel_sum_q, sel_sum_d;
    logic          sum_rd_q, sum_rd_d;

    logic          cpu_clr;
    logic          sum_clr;
    logic          set_commit;
    logic          sweep_start;
    logic          ram_we;
    logic [AW-1:0] ram_wr_ad;
    logic          ram_wr_data;
    logic          ram_rd_data;

    assign cpu_clr = cpu.CPU_WR & cpu.CPU_CS_RAM;
    assign sum_clr = cpu.CPU_WR & cpu.CPU_CS_SUM;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_ad_d   = pend_ad_q;
        summary_d   = summary_q;
        set_commit  = 1'b0;
        sweep_start = 1'b0;
        ram_we      = 1'b0;
        ram_wr_ad   = cnt_q;
        ram_wr_data = 1'b0;

        // Write-port arbitration: CPU clear > sprite set > sweep.
        if (cpu_clr) begin
            ram_we      = 1'b1;
            ram_wr_ad   = cpu.CPU_AD;
            ram_wr_data = 1'b0;
            // A live set that loses is parked; an occupied pending entry
            // already holds the only address the renderer could be sending.
            if (SPRCOLL && !pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_ad_d  = SPRCOLL_AD;
            end
        end else if (pend_vld_q) begin
            ram_we      = 1'b1;
            ram_wr_ad   = pend_ad_q;
            ram_wr_data = 1'b1;
            set_commit  = 1'b1;
            // Same-address live set is redundant with the drained entry.
            pend_vld_d  = SPRCOLL && (SPRCOLL_AD != pend_ad_q);
            pend_ad_d   = SPRCOLL_AD;
        end else if (SPRCOLL) begin
            ram_we      = 1'b1;
            ram_wr_ad   = SPRCOLL_AD;
            ram_wr_data = 1'b1;
            set_commit  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (CLR_ALL) begin
                    state_d     = SWEEP;
                    cnt_d       = '0;
                    sweep_start = 1'b1;
                end
            end
            SWEEP: begin
                if (CLR_ALL) begin
                    cnt_d       = '0;
                    sweep_start = 1'b1;
                end else if (!ram_we) begin
                    // Only advance when the port was free; otherwise stall.
                    ram_we      = 1'b1;
                    ram_wr_ad   = cnt_q;
                    ram_wr_data = 1'b0;
                    if (cnt_q == LAST_AD) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A committing set wins over any clear in the same cycle.
        if (set_commit) begin
            summary_d = 1'b1;
        end else if (sum_clr || sweep_start) begin
            summary_d = 1'b0;
        end
    end

    // Read path: select and summary value are sampled alongside the RAM read
    // so CPU_DO always shows the previous cycle's state.
    always_comb begin
        sel_sum_d = cpu.CPU_CS_SUM;
        sum_rd_d  = summary_q;
    end

    always_ff @(posedge VCLKx8 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_ad_q  <= '0;
            summary_q  <= 1'b0;
            // Selecting a cleared summary yields 8'hFE out of reset.
            sel_sum_q  <= 1'b1;
            sum_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_ad_q  <= pend_ad_d;
            summary_q  <= summary_d;
            sel_sum_q  <= sel_sum_d;
            sum_rd_q   <= sum_rd_d;
        end
    end

    segasys1_sprcoll_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (VCLKx8),
        .we      (ram_we),
        .wr_ad   (ram_wr_ad),
        .wr_data (ram_wr_data),
        .rd_ad   (cpu.CPU_AD),
        .rd_data (ram_rd_data)
    );

    assign cpu.CPU_DO = {7'b1111111, (sel_sum_q ? sum_rd_q : ram_rd_data)};
    assign BUSY       = (state_q == SWEEP);
    assign SUMMARY    = summary_q;

endmodule

// File: tb/tb_segasys1_sprcoll.sv
// ---------------------------------------------------------------------------
// tb_segasys1_sprcoll
// Directed steps followed by a randomized phase, checked against a
// bit-array reference model of the collision store.
// ---------------------------------------------------------------------------
module tb_segasys1_sprcoll;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sprcoll;
    logic [9:0] sprcoll_ad;
    logic       clr_all;
    logic       busy;
    logic       summary;

    segasys1_sprcoll_if #(.AW(10)) cpu_if ();

    segasys1_sprcoll #(.AW(10)) dut (
        .VCLKx8     (clk),
        .RST_N      (rst_n),
        .SPRCOLL    (sprcoll),
        .SPRCOLL_AD (sprcoll_ad),
        .CLR_ALL    (clr_all),
        .BUSY       (busy),
        .SUMMARY    (summary),
        .cpu        (cpu_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt = 0;

    // Reference model state
    bit         mem_m [0:1023];
    bit         sum_m;
    bit         pend_m;
    logic [9:0] pend_a;
    bit         busy_m;
    int         cnt_m;
    logic [7:0] exp_do;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sum_m  = 0;
        busy_m = 0;
        pend_m = 0;
        cnt_m  = 0;
        exp_do = 8'hFE;
    endtask

    // Applies one cycle of the collision-store rules to the model, using the
    // inputs present just before the clock edge.
    task automatic model_step();
        bit clr;
        bit committed;
        if (!rst_n) begin
            model_reset();
            return;
        end
        clr = cpu_if.CPU_WR && cpu_if.CPU_CS_RAM;
        exp_do = {7'h7F, cpu_if.CPU_CS_SUM ? sum_m : mem_m[cpu_if.CPU_AD]};
        committed = 0;
        if (clr) begin
            mem_m[cpu_if.CPU_AD] = 0;
            if (sprcoll && !pend_m) begin
                pend_m = 1;
                pend_a = sprcoll_ad;
            end
        end else if (pend_m) begin
            mem_m[pend_a] = 1;
            committed = 1;
            if (sprcoll && sprcoll_ad != pend_a) pend_a = sprcoll_ad;
            else pend_m = 0;
        end else if (sprcoll) begin
            mem_m[sprcoll_ad] = 1;
            committed = 1;
        end else if (busy_m && !clr_all) begin
            mem_m[cnt_m] = 0;
            if (cnt_m == 1023) busy_m = 0;
            else cnt_m++;
        end
        if (clr_all) begin
            busy_m = 1;
            cnt_m  = 0;
        end
        if (committed) sum_m = 1;
        else if ((cpu_if.CPU_WR && cpu_if.CPU_CS_SUM) || clr_all) sum_m = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
    endtask

    task automatic rd_ram(input string tag, input logic [9:0] a, input logic [7:0] want);
        cpu_if.CPU_AD     = a;
        cpu_if.CPU_CS_SUM = 1'b0;
        cpu_if.CPU_CS_RAM = 1'b0;
        cpu_if.CPU_WR     = 1'b0;
        tick();
        chk(tag, cpu_if.CPU_DO, want);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 1100) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    int         sp_hold;
    int         sp_gap;
    bit         last_wr;
    bit         do_wr;
    bit         wr_sum;

    initial begin
        rst_n             = 1'b0;
        sprcoll           = 1'b0;
        sprcoll_ad        = '0;
        clr_all           = 1'b0;
        cpu_if.CPU_AD     = '0;
        cpu_if.CPU_CS_RAM = 1'b0;
        cpu_if.CPU_CS_SUM = 1'b0;
        cpu_if.CPU_WR     = 1'b0;
        pend_a            = '0;
        for (int i = 0; i < 1024; i++) mem_m[i] = 0;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("reset_do", cpu_if.CPU_DO, 8'hFE);
        chk("reset_busy", busy, 1'b0);
        chk("reset_sum", summary, 1'b0);
        rst_n = 1'b1;
        tick();

        // Initial clear sweep: BUSY for exactly 1024 cycles
        busy_cnt = 0;
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        chk("sweep1_busy_rise", busy, 1'b1);
        wait_idle("sweep1_timeout");
        chk("sweep1_len", busy_cnt, 1024);
        rd_ram("rd_000", 10'h000, 8'hFE);
        rd_ram("rd_1ff", 10'h1FF, 8'hFE);
        rd_ram("rd_3ff", 10'h3FF, 8'hFE);
        chk("sum_after_sweep", summary, 1'b0);

        // Two-cycle sprite set at 0x0A5
        sprcoll = 1'b1;
        sprcoll_ad = 10'h0A5;
        tick();
        tick();
        sprcoll = 1'b0;
        chk("sum_after_set", summary, 1'b1);
        rd_ram("rd_0a5_set", 10'h0A5, 8'hFF);
        rd_ram("rd_0a4", 10'h0A4, 8'hFE);

        // CPU clear of 0x0A5 collides with set of 0x133: set deferred
        cpu_if.CPU_AD = 10'h0A5;
        cpu_if.CPU_CS_RAM = 1'b1;
        cpu_if.CPU_WR = 1'b1;
        sprcoll = 1'b1;
        sprcoll_ad = 10'h133;
        tick();
        sprcoll = 1'b0;
        rd_ram("defer_133_early", 10'h133, 8'hFE);
        rd_ram("defer_133_late", 10'h133, 8'hFF);
        rd_ram("clr_0a5", 10'h0A5, 8'hFE);

        // Same-cycle clear and set at 0x200: final bit is 1
        cpu_if.CPU_AD = 10'h200;
        cpu_if.CPU_CS_RAM = 1'b1;
        cpu_if.CPU_WR = 1'b1;
        sprcoll = 1'b1;
        sprcoll_ad = 10'h200;
        tick();
        sprcoll = 1'b0;
        cpu_if.CPU_WR = 1'b0;
        cpu_if.CPU_CS_RAM = 1'b0;
        tick();
        rd_ram("same_ad_200", 10'h200, 8'hFF);

        // Summary clear coinciding with a set keeps it set
        cpu_if.CPU_CS_SUM = 1'b1;
        cpu_if.CPU_WR = 1'b1;
        sprcoll = 1'b1;
        sprcoll_ad = 10'h050;
        tick();
        sprcoll = 1'b0;
        cpu_if.CPU_WR = 1'b0;
        chk("sum_set_wins", summary, 1'b1);
        tick();
        chk("sum_rd_one", cpu_if.CPU_DO, 8'hFF);
        cpu_if.CPU_WR = 1'b1;
        tick();
        cpu_if.CPU_WR = 1'b0;
        chk("sum_cleared", summary, 1'b0);
        tick();
        chk("sum_rd_zero", cpu_if.CPU_DO, 8'hFE);
        cpu_if.CPU_CS_SUM = 1'b0;

        // Sweep with two injected sets: one behind the counter, one ahead
        busy_cnt = 0;
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        repeat (10'h100) tick();
        sprcoll = 1'b1;
        sprcoll_ad = 10'h010;
        tick();
        sprcoll = 1'b0;
        repeat (3) tick();
        sprcoll = 1'b1;
        sprcoll_ad = 10'h300;
        tick();
        sprcoll = 1'b0;
        wait_idle("sweep2_timeout");
        chk("sweep2_len", busy_cnt, 1026);
        rd_ram("swept_010_kept", 10'h010, 8'hFF);
        rd_ram("swept_300_gone", 10'h300, 8'hFE);
        rd_ram("swept_200_gone", 10'h200, 8'hFE);

        // Randomized traffic against the model
        sp_hold = 0;
        sp_gap  = 0;
        last_wr = 0;
        for (int c = 0; c < 600; c++) begin
            if (sp_hold > 0) begin
                sprcoll = 1'b1;
                sp_hold--;
            end else if (sp_gap > 0) begin
                sprcoll = 1'b0;
                sp_gap--;
            end else if ($urandom_range(0, 2) == 0) begin
                sprcoll = 1'b1;
                sprcoll_ad = 10'($urandom_range(0, 31));
                sp_hold = $urandom_range(0, 1);
                sp_gap = 3;
            end else begin
                sprcoll = 1'b0;
            end
            do_wr  = !last_wr && ($urandom_range(0, 4) == 0);
            wr_sum = ($urandom_range(0, 3) == 0);
            cpu_if.CPU_WR     = do_wr;
            cpu_if.CPU_CS_SUM = wr_sum;
            cpu_if.CPU_CS_RAM = do_wr && !wr_sum;
            cpu_if.CPU_AD     = 10'($urandom_range(0, 31));
            last_wr = do_wr;
            tick();
            chk("rnd_do", cpu_if.CPU_DO, exp_do);
            chk("rnd_sum", summary, sum_m);
        end
        sprcoll = 1'b0;
        cpu_if.CPU_WR = 1'b0;
        cpu_if.CPU_CS_RAM = 1'b0;
        cpu_if.CPU_CS_SUM = 1'b0;
        tick();

        // Asynchronous reset in the middle of a sweep
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        repeat (10'h180) tick();
        chk("busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_busy_async", busy, 1'b0);
        chk("rst_sum_async", summary, 1'b0);
        chk("rst_do_async", cpu_if.CPU_DO, 8'hFE);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("busy_after_rst", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
